// File: rtl/mem_bus_responder_pkg.sv
// Shared types for the memory bus responder: FSM states, request codes and request decode.
package mem_bus_responder_pkg;

    localparam int unsigned DefDataW   = 14;
    localparam int unsigned DefAddrW   = 12;
    localparam int unsigned DefRamDepth = 1024;
    localparam int unsigned WaitCntW   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAccess,
        StCapture,
        StRespond,
        StRelease
    } state_e;

    typedef enum logic [1:0] {
        ReqRomRd,
        ReqRamRd,
        ReqRamWr,
        ReqIllegal
    } req_e;

    // Multiple strobes, or a RAM access outside the populated range, is rejected.
    function automatic req_e decode_req(input logic rom_rd, input logic ram_rd,
                                        input logic ram_wr, input logic ram_in_range);
        req_e req;
        case ({rom_rd, ram_rd, ram_wr})
            3'b100:  req = ReqRomRd;
            3'b010:  req = ram_in_range ? ReqRamRd : ReqIllegal;
            3'b001:  req = ram_in_range ? ReqRamWr : ReqIllegal;
            default: req = ReqIllegal;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/mem_bus_responder_wait.sv
// Loadable 4-bit down-counter that stops at zero; done is high while the count is zero.
module wait_counter
    import mem_bus_responder_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [WaitCntW-1:0] value_i,
    output logic                done_o
);

    logic [WaitCntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: serves ROM/RAM requests from the control unit with optional
// wait states, range checking and a one-cycle ready/bus_err completion pulse.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned RAM_DEPTH   = DefRamDepth,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              rom_rd,
    input  logic              ram_rd,
    input  logic              ram_wr,
    output logic [DATA_W-1:0] rdata_out,
    output logic              ready,
    output logic              bus_err,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [WaitCntW-1:0] WaitLoad =
        (WAIT_CYCLES > 0) ? WaitCntW'(WAIT_CYCLES - 1) : '0;
    localparam logic [ADDR_W:0] RamLimit = (ADDR_W + 1)'(RAM_DEPTH);

    state_e            state_q;
    req_e              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              bus_err_q;
    logic              rom_en_q;
    logic              ram_en_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_d_q;

    logic              any_strobe;
    logic              ram_in_range;
    req_e              req_in;
    logic              cnt_load;
    logic              cnt_done;
    logic              enter_access;
    req_e              acc_req;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;

    // Enables are registered on the edge entering ACCESS; without wait states that edge is
    // also the accept edge, so the just-sampled request stands in for the latched copy.
    always_comb begin
        any_strobe   = rom_rd | ram_rd | ram_wr;
        ram_in_range = ({1'b0, addr_in} < RamLimit);
        req_in       = decode_req(rom_rd, ram_rd, ram_wr, ram_in_range);
        cnt_load     = (state_q == StIdle) && any_strobe && (req_in != ReqIllegal)
                       && (WAIT_CYCLES != 0);
        enter_access = ((state_q == StIdle) && any_strobe && (req_in != ReqIllegal)
                        && (WAIT_CYCLES == 0))
                       || ((state_q == StWait) && cnt_done);
        acc_req      = (state_q == StIdle) ? req_in : req_q;
        acc_addr     = (state_q == StIdle) ? addr_in : addr_q;
        acc_wdata    = (state_q == StIdle) ? wdata_in : wdata_q;
    end

    wait_counter u_wait_counter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (cnt_load),
        .value_i (WaitLoad),
        .done_o  (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            req_q      <= ReqRomRd;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            rom_en_q   <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            rom_addr_q <= '0;
            ram_addr_q <= '0;
            ram_d_q    <= '0;
        end else begin
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
            rom_en_q  <= 1'b0;
            ram_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;

            if (enter_access) begin
                rom_en_q <= (acc_req == ReqRomRd);
                ram_en_q <= (acc_req == ReqRamRd) || (acc_req == ReqRamWr);
                ram_we_q <= (acc_req == ReqRamWr);
                if (acc_req == ReqRomRd) begin
                    rom_addr_q <= acc_addr;
                end else begin
                    ram_addr_q <= acc_addr;
                end
                if (acc_req == ReqRamWr) begin
                    ram_d_q <= acc_wdata;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (any_strobe) begin
                        req_q   <= req_in;
                        addr_q  <= addr_in;
                        wdata_q <= wdata_in;
                        if (req_in == ReqIllegal) begin
                            state_q <= StCapture;
                        end else if (WAIT_CYCLES != 0) begin
                            state_q <= StWait;
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    if (cnt_done) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: state_q <= StCapture;
                StCapture: begin
                    if (req_q == ReqRomRd) begin
                        rdata_q <= rom_q;
                    end else if (req_q == ReqRamRd) begin
                        rdata_q <= ram_q;
                    end
                    state_q <= StRespond;
                end
                StRespond: begin
                    ready_q   <= 1'b1;
                    bus_err_q <= (req_q == ReqIllegal);
                    state_q   <= StRelease;
                end
                StRelease: begin
                    // Hold here until the initiator drops its strobe so it is served once.
                    if (!any_strobe) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rdata_out = rdata_q;
    assign ready     = ready_q;
    assign bus_err   = bus_err_q;
    assign rom_addr  = rom_addr_q;
    assign rom_en    = rom_en_q;
    assign ram_addr  = ram_addr_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_d     = ram_d_q;

endmodule
